dma_controller: RTL and testbench

//  Sequences block transfers from the external device into memory without CPU data moves.
//  The CPU services the device interrupt and issues one command (base address, length).
//  The block requests the bus (BR/BG), steps dev_offset through the device blocks and writes

---
 rtl/dma_controller.sv | 141 ++++++++++++++
 tb/tb_dma_controller.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// dma_controller
//   Moves up to NUM_BLOCKS device blocks into memory for one CPU command.
//   The CPU issues a command (base word address, length in words). The block
//   requests the bus, selects each device block in turn through dev_offset and
//   writes it to memory as one BLOCK_WORDS-word burst. When the last burst has
//   been acknowledged it raises dma_done for one cycle.
//
//   Optional feature: define DMA_CYCLE_STEAL_EN to release the bus for one
//   cycle after every non-final burst so the CPU can use it between bursts.
//   With the macro undefined the bus is held for the whole transfer.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/addr/length   one-cycle command strobe with base address and length
//   BR / BG                 bus request out / bus grant in
//   dev_offset, dev_data    device block select (all-ones = none) and block data
//   mem_write, mem_addr,    burst write strobe, burst base address,
//   mem_data, mem_ack       burst data (combinational from dev_data), burst done
//   busy, dma_done          not-idle flag, one-cycle completion interrupt
//   dbg_state               current FSM state, for observation only
//
// Bus handshake: BR is the request and BG the grant. A burst is only presented
// (mem_write high) while the grant is held; mem_ack is honoured only in a cycle
// where a burst is presented and wins over a grant withdrawn in that same cycle.
// A withdrawn grant without an ack aborts the burst, which is retried later.
module dma_controller #(
   parameter int WORD_SIZE   = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int NUM_BLOCKS  = 3,
   parameter int OFF_W       = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         cmd_valid,
   input  logic [15:0]                  cmd_addr,
   input  logic [15:0]                  cmd_length,
   output logic                         BR,
   input  logic                         BG,
   output logic [OFF_W-1:0]             dev_offset,
   input  logic [WORD_SIZE*BLOCK_WORDS-1:0] dev_data,
   output logic                         mem_write,
   output logic [15:0]                  mem_addr,
   output logic [WORD_SIZE*BLOCK_WORDS-1:0] mem_data,
   input  logic                         mem_ack,
   output logic                         busy,
   output logic                         dma_done,
   output logic [2:0]                   dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      XFER    = 3'd2,
      RELEASE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [OFF_W-1:0] idx, idx_nx;
   logic [OFF_W-1:0] nblk, nblk_in;
   logic [15:0]      base;
   logic [15:0]      len_blk;

   // Whole blocks requested, clamped to what the device holds; the two low
   // length bits (a partial block) are dropped.
   assign len_blk = cmd_length >> 2;
   assign nblk_in = (len_blk >= 16'(NUM_BLOCKS)) ? OFF_W'(NUM_BLOCKS) : OFF_W'(len_blk);

   assign mem_data  = dev_data;
   assign dbg_state = state;

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               idx_nx   = '0;
               state_nx = (nblk_in != '0) ? REQ : DONE;
            end
         end
         REQ: begin
            if (BG) state_nx = XFER;
         end
         XFER: begin
            if (mem_ack) begin
               idx_nx = idx + OFF_W'(1);
               if (idx + OFF_W'(1) == nblk) begin
                  state_nx = DONE;
               end else begin
`ifdef DMA_CYCLE_STEAL_EN
                  state_nx = RELEASE;
`else
                  state_nx = XFER;
`endif
               end
            end else if (!BG) begin
               // grant lost mid-burst: same idx is retried after re-grant
               state_nx = REQ;
            end
         end
         RELEASE: state_nx = REQ;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change together with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         nblk       <= '0;
         base       <= '0;
         BR         <= 1'b0;
         mem_write  <= 1'b0;
         busy       <= 1'b0;
         dma_done   <= 1'b0;
         mem_addr   <= '0;
         dev_offset <= '1;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (state == IDLE && cmd_valid) begin
            base <= cmd_addr;
            nblk <= nblk_in;
         end
         BR        <= (state_nx == REQ) || (state_nx == XFER);
         mem_write <= (state_nx == XFER);
         busy      <= (state_nx != IDLE);
         dma_done  <= (state_nx == DONE);
         if (state_nx == XFER) begin
            dev_offset <= idx_nx;
            mem_addr   <= base + 16'(idx_nx) * 16'(BLOCK_WORDS);
         end else begin
            dev_offset <= '1;
         end
      end
   end

endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller
//   Bench for dma_controller: reset values, table-driven commands, randomized
//   commands against a transfer-list model, and hand-written sequences for
//   grant loss, ignored commands, zero length and reset mid-transfer.
module tb_dma_controller;

   localparam int NB = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [15:0] cmd_addr = '0;
   logic [15:0] cmd_length = '0;
   wire         BR;
   wire         BG;
   wire  [1:0]  dev_offset;
   wire  [63:0] dev_data;
   wire         mem_write;
   wire  [15:0] mem_addr;
   wire  [63:0] mem_data;
   wire         mem_ack;
   wire         busy;
   wire         dma_done;
   wire  [2:0]  dbg_state;

   logic [63:0] storage [0:2];

   // bus/memory side: either the automatic agent or the hand sequences drive it
   bit   auto_bus = 1'b0;
   logic agent_bg = 1'b0, agent_ack = 1'b0;
   logic man_bg = 1'b0, man_ack = 1'b0;
   int   bg_dly = 0, ack_dly = 0;

   assign BG       = auto_bus ? agent_bg  : man_bg;
   assign mem_ack  = auto_bus ? agent_ack : man_ack;
   assign dev_data = (dev_offset < 2'd3) ? storage[dev_offset] : 64'bz;

   dma_controller dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
      .cmd_length(cmd_length), .BR(BR), .BG(BG), .dev_offset(dev_offset),
      .dev_data(dev_data), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_ack(mem_ack), .busy(busy), .dma_done(dma_done),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;
   logic [81:0] exp_q[$];
   int bursts = 0, done_cnt = 0, br_gaps = 0;
   logic [15:0] last_addr = '0;

   task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // automatic bus agent: grant bg_dly cycles after request, ack each burst
   // ack_dly cycles after it is presented, score every acknowledged burst
   initial begin : agent
      int bc, ac;
      logic [81:0] exp_b;
      bc = 0; ac = 0;
      forever begin
         @(negedge clk);
         agent_ack = 1'b0;
         if (!auto_bus || !reset_n) begin
            agent_bg = 1'b0; bc = 0; ac = 0;
         end else begin
            if (BR) begin
               if (bc >= bg_dly) agent_bg = 1'b1;
               bc++;
            end else begin
               agent_bg = 1'b0; bc = 0;
            end
            if (mem_write) begin
               if (ac >= ack_dly) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_burst", {mem_addr, dev_offset, mem_data}, '0);
                  end else begin
                     exp_b = exp_q.pop_front();
                     check("burst", {mem_addr, dev_offset, mem_data}, exp_b);
                  end
                  last_addr = mem_addr;
                  bursts++;
                  agent_ack = 1'b1;
                  ac = 0;
               end else begin
                  ac++;
               end
            end else begin
               ac = 0;
            end
         end
      end
   end

   // event monitor: completion pulses and bus-release gaps inside a transfer
   initial begin : monitor
      logic prev_br;
      prev_br = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_br = 1'b0;
         end else begin
            if (dma_done) done_cnt++;
            if (busy && !BR && !dma_done && prev_br) br_gaps++;
            prev_br = BR;
         end
      end
   end

   task automatic do_cmd(input logic [15:0] addr, input logic [15:0] len,
                         input int bgd, input int ackd,
                         input int exp_nblk, input logic [15:0] exp_last);
      int nb, d0, b0, g0, exp_gaps;
      bit got;
      bg_dly = bgd; ack_dly = ackd;
      for (int i = 0; i < NB; i++) storage[i] = {$urandom, $urandom};
      nb = (int'(len) / 4 > NB) ? NB : int'(len) / 4;
      for (int i = 0; i < nb; i++)
         exp_q.push_back({16'(int'(addr) + 4 * i), 2'(i), storage[i]});
`ifdef DMA_CYCLE_STEAL_EN
      exp_gaps = (exp_nblk > 0) ? exp_nblk - 1 : 0;
`else
      exp_gaps = 0;
`endif
      d0 = done_cnt; b0 = bursts; g0 = br_gaps;
      auto_bus = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = addr; cmd_length = len;
      @(negedge clk);
      cmd_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (dma_done) got = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      check("done_seen", got, 1'b1);
      check("done_count", done_cnt - d0, 1);
      check("burst_count", bursts - b0, exp_nblk);
      check("br_gaps", br_gaps - g0, exp_gaps);
      check("queue_empty", exp_q.size(), 0);
      check("idle_br", BR, 1'b0);
      check("idle_busy", busy, 1'b0);
      if (exp_nblk > 0) check("last_addr", last_addr, exp_last);
      exp_q.delete();
   endtask

   task automatic wait_write(input int bound);
      for (int k = 0; k < bound && !mem_write; k++) @(negedge clk);
      check("wait_write", mem_write, 1'b1);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [15:0] len;
      int          bgd;
      int          ackd;
      int          exp_nblk;
      logic [15:0] exp_last;
   } vec_t;

   vec_t vecs [8];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int d0;
      logic [15:0] ra, rl;
      int nb;

      vecs[0] = '{16'h0100, 16'd12, 2, 3, 3, 16'h0108};
      vecs[1] = '{16'h0040, 16'd40, 0, 0, 3, 16'h0048};
      vecs[2] = '{16'h1230, 16'd7,  1, 2, 1, 16'h1230};
      vecs[3] = '{16'hFFFC, 16'd8,  1, 1, 2, 16'h0000};
      vecs[4] = '{16'h0500, 16'd3,  0, 0, 0, 16'h0000};
      vecs[5] = '{16'h0000, 16'd0,  0, 0, 0, 16'h0000};
      vecs[6] = '{16'h7FF0, 16'd16, 3, 1, 3, 16'h7FF8};
      vecs[7] = '{16'h0010, 16'd4,  2, 4, 1, 16'h0010};
      for (int i = 0; i < NB; i++) storage[i] = {$urandom, $urandom};

      // reset values
      repeat (2) @(negedge clk);
      check("rst_br", BR, 1'b0);
      check("rst_mem_write", mem_write, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", dma_done, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_dev_offset", dev_offset, 2'b11);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // zero length: straight to completion, one busy cycle, no request
      auto_bus = 1'b0;
      cmd_valid = 1'b1; cmd_addr = 16'h0123; cmd_length = 16'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("zero_done", dma_done, 1'b1);
      check("zero_busy", busy, 1'b1);
      check("zero_br", BR, 1'b0);
      @(negedge clk);
      check("zero_done_off", dma_done, 1'b0);
      check("zero_busy_off", busy, 1'b0);
      check("zero_br_after", BR, 1'b0);

      // table-driven commands
      for (int i = 0; i < 8; i++)
         do_cmd(vecs[i].addr, vecs[i].len, vecs[i].bgd, vecs[i].ackd,
                vecs[i].exp_nblk, vecs[i].exp_last);

      // grant loss mid-burst, ignored command, ack winning over grant drop
      auto_bus = 1'b0; man_bg = 1'b0; man_ack = 1'b0;
      for (int i = 0; i < NB; i++) storage[i] = {$urandom, $urandom};
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 16'h0200; cmd_length = 16'd12;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("req_br", BR, 1'b1);
      check("req_mem_write", mem_write, 1'b0);
      check("req_busy", busy, 1'b1);
      man_bg = 1'b1;
      @(negedge clk);
      check("lat_mem_write", mem_write, 1'b1);
      check("b0_addr", mem_addr, 16'h0200);
      check("b0_off", dev_offset, 2'd0);
      check("b0_data", mem_data, storage[0]);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
`ifdef DMA_CYCLE_STEAL_EN
      check("release_br", BR, 1'b0);
      check("release_busy", busy, 1'b1);
`endif
      wait_write(10);
      check("b1_addr", mem_addr, 16'h0204);
      check("b1_off", dev_offset, 2'd1);
      cmd_valid = 1'b1; cmd_addr = 16'h9990; cmd_length = 16'd4;
      man_bg = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("drop_mem_write", mem_write, 1'b0);
      check("drop_br", BR, 1'b1);
      check("drop_off", dev_offset, 2'b11);
      check("drop_busy", busy, 1'b1);
      repeat (2) @(negedge clk);
      check("hold_br", BR, 1'b1);
      check("hold_mem_write", mem_write, 1'b0);
      man_bg = 1'b1;
      @(negedge clk);
      check("retry_mem_write", mem_write, 1'b1);
      check("retry_addr", mem_addr, 16'h0204);
      check("retry_off", dev_offset, 2'd1);
      check("retry_data", mem_data, storage[1]);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      wait_write(10);
      check("b2_addr", mem_addr, 16'h0208);
      check("b2_off", dev_offset, 2'd2);
      check("b2_data", mem_data, storage[2]);
      man_bg = 1'b0; man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      check("fin_done", dma_done, 1'b1);
      check("fin_br", BR, 1'b0);
      check("fin_mem_write", mem_write, 1'b0);
      @(negedge clk);
      check("fin_done_off", dma_done, 1'b0);
      check("fin_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      check("ignored_cmd_busy", busy, 1'b0);

      // reset pulsed during the third burst
      for (int i = 0; i < NB; i++) storage[i] = {$urandom, $urandom};
      for (int i = 0; i < NB; i++) exp_q.push_back({16'(16'h0300 + 4 * i), 2'(i), storage[i]});
      bg_dly = 1; ack_dly = 6; auto_bus = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 16'h0300; cmd_length = 16'd12;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 200 && !(mem_write && dev_offset == 2'd2); k++) @(negedge clk);
      check("reach_b2", {mem_write, dev_offset}, {1'b1, 2'd2});
      d0 = done_cnt;
      #2 reset_n = 1'b0;
      #1;
      check("arst_br", BR, 1'b0);
      check("arst_mem_write", mem_write, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", dma_done, 1'b0);
      check("arst_mem_addr", mem_addr, 16'h0000);
      check("arst_dev_offset", dev_offset, 2'b11);
      check("arst_outstanding", exp_q.size(), 1);
      exp_q.delete();
      auto_bus = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("arst_no_done", done_cnt - d0, 0);
      check("arst_idle", busy, 1'b0);
      do_cmd(16'h0400, 16'd8, 1, 1, 2, 16'h0404);

      // randomized commands against the transfer-list model
      for (int r = 0; r < 20; r++) begin
         ra = 16'($urandom_range(0, 65535));
         rl = 16'($urandom_range(0, 60));
         nb = (int'(rl) / 4 > NB) ? NB : int'(rl) / 4;
         do_cmd(ra, rl, $urandom_range(0, 3), $urandom_range(0, 3),
                nb, 16'(int'(ra) + 4 * (nb - 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
